dmem_responder: RTL and testbench

Memory-side responder for the pipeline's data-memory load/store requests. It accepts one LW/SW request at a time over a valid/ready handshake and inserts a parameterised number of wait states. It then performs the word access on an internal array and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory and lets the core be exercised against a slow memory.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Slow data-memory responder: accepts one LW/SW at a time, waits WAIT_CYCLES,
// performs the word access on an internal array and returns a held response.
module dmem_responder #(
   parameter int         DEPTH       = 1024,
   parameter int         ADDR_W      = 10,
   parameter int         WAIT_CYCLES = 2,
   parameter logic [5:0] LW_OP       = 6'b100011,
   parameter logic [5:0] SW_OP       = 6'b101011
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshakes: a request transfers on an edge where req_valid && req_ready;
   // a response transfers on an edge where rsp_valid && rsp_ready, and
   // rsp_rdata/rsp_err are held stable for as long as rsp_valid is high.

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  counter;
   logic [5:0]        op_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       mem [DEPTH];

   logic [ADDR_W-1:0] idx;
   logic              is_load;
   logic              is_store;
   logic              range_bad;
   logic              err;
   logic              commit;
   logic              accept;

   assign idx       = addr_q[ADDR_W+1:2];
   assign is_load   = (op_q == LW_OP);
   assign is_store  = (op_q == SW_OP);
   assign err       = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0) ||
                      range_bad || !(is_load || is_store);
   assign commit    = (state == WAIT) && (counter == '0);
   assign accept    = (state == IDLE) && req_valid && req_ready;
   assign state_dbg = state;

   // Only a partially populated index space can overflow the array.
   generate
      if (DEPTH < (1 << ADDR_W)) begin : g_range
         assign range_bad = (32'(idx) >= 32'(DEPTH));
      end else begin : g_full
         assign range_bad = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (accept) begin
         op_q    <= req_op;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Kept separate from the control state so the array stays RAM-like; reset
   // suppresses the commit so an aborted store never lands.
   always_ff @(posedge clock) begin
      if (!reset && commit && is_store && !err)
         mem[idx] <= wdata_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         counter   <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  counter   <= CNT_W'(WAIT_CYCLES);
                  state     <= WAIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WAIT: begin
               if (counter != '0) begin
                  counter <= counter - CNT_W'(1);
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= err;
                  rsp_rdata <= (is_load && !err) ? mem[idx] : 32'h0;
               end
            end
            RESP: begin
               // req_ready rises with the return to IDLE, so the earliest
               // re-accept is the following edge.
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for the main
// sequence and a WAIT_CYCLES=0 instance for back-to-back streaming.
module tb_dmem_responder;

   localparam int         WC = 2;
   localparam logic [5:0] LW = 6'b100011;
   localparam logic [5:0] SW = 6'b101011;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;

   logic        req_valid = 1'b0, rsp_ready = 1'b1;
   logic [5:0]  req_op = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  state_dbg;

   logic        req0_valid = 1'b0, rsp0_ready = 1'b1;
   logic [5:0]  req0_op = '0;
   logic [31:0] req0_addr = '0, req0_wdata = '0;
   logic        req0_ready, rsp0_valid, rsp0_err, busy0;
   logic [31:0] rsp0_rdata;
   logic [1:0]  state0_dbg;

   logic [32:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   logic [5:0]  s_op[4];
   logic [31:0] s_addr[4], s_data[4], s_exp[4];
   logic [31:0] model[int];
   logic [31:0] raddr, rdata;
   logic [32:0] e;
   int          k, n_rsp, last_acc, n;
   logic        acc_now;

   dmem_responder #(.WAIT_CYCLES(WC)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
   );

   dmem_responder #(.WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset), .req_valid(req0_valid), .req_ready(req0_ready),
      .req_op(req0_op), .req_addr(req0_addr), .req_wdata(req0_wdata),
      .rsp_valid(rsp0_valid), .rsp_ready(rsp0_ready), .rsp_rdata(rsp0_rdata),
      .rsp_err(rsp0_err), .busy(busy0), .state_dbg(state0_dbg)
   );

   // clock / reset
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_vec++;
      assert (got === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, expv);
      end
   endtask

   // Drive one request on the WC=2 instance, check latency and response,
   // optionally holding rsp_ready low for 'hold' cycles.
   task automatic do_req(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_err,
                         input logic [31:0] exp_rdata, input int hold);
      int          w;
      logic [32:0] ex;
      logic [33:0] seen;
      exp_q.push_back({exp_err, exp_rdata});
      @(negedge clock);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      rsp_ready = (hold == 0);
      w = 0;
      while (req_ready !== 1'b1 && w < 20) begin @(negedge clock); w++; end
      chk({tag, "_acc"}, 64'(w < 20), 64'(1));
      @(posedge clock); #1;
      req_valid = 1'b0; req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
      chk({tag, "_busy"}, 64'({busy, req_ready}), 64'(2'b10));
      w = 0;
      while (rsp_valid !== 1'b1 && w < 20) begin @(posedge clock); #1; w++; end
      chk({tag, "_lat"}, 64'(w), 64'(WC + 1));
      ex = exp_q.pop_front();
      chk({tag, "_rsp"}, 64'({rsp_err, rsp_rdata}), 64'(ex));
      if (hold > 0) begin
         seen = {rsp_valid, rsp_err, rsp_rdata};
         for (int i = 0; i < hold; i++) begin
            if (i == 1) begin req_valid = 1'b1; req_op = SW; req_addr = 32'h0; end
            if (i == 2) req_valid = 1'b0;
            @(posedge clock); #1;
            chk({tag, "_hold"}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(seen));
            chk({tag, "_hold_rdy"}, 64'(req_ready), 64'(0));
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(posedge clock); #1;
      chk({tag, "_drop"}, 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
      if (hold > 0) begin
         @(posedge clock); #1;
         chk({tag, "_noacc"}, 64'(busy), 64'(0));
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, busy}), 64'(0));
      chk("rst_state", 64'(state_dbg), 64'(0));
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      chk("rst_ready", 64'(req_ready), 64'(1));

      // store/load, errors, no corruption
      do_req("sw10",   SW, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        0);
      do_req("lw10",   LW, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 0);
      do_req("lw13",   LW, 32'h13,   32'h0,        1'b1, 32'h0,        0);
      do_req("lw10b",  LW, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 0);
      do_req("sw0",    SW, 32'h0,    32'h0BADF00D, 1'b0, 32'h0,        0);
      do_req("sw1000", SW, 32'h1000, 32'h11111111, 1'b1, 32'h0,        0);
      do_req("lw0",    LW, 32'h0,    32'h0,        1'b0, 32'h0BADF00D, 0);
      do_req("badop",  6'b000000, 32'h10, 32'h0,   1'b1, 32'h0,        0);
      do_req("swmis",  SW, 32'h12,   32'h55555555, 1'b1, 32'h0,        0);
      do_req("lwhi",   LW, 32'h8000_0010, 32'h0,   1'b1, 32'h0,        0);
      do_req("hold",   LW, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 5);
      do_req("lw0b",   LW, 32'h0,    32'h0,        1'b0, 32'h0BADF00D, 0);

      // random store/readback against a local model
      for (int i = 0; i < 4; i++) begin
         raddr = {20'h0, 10'($urandom_range(64, 1023)), 2'b00};
         rdata = $urandom;
         model[int'(raddr)] = rdata;
         do_req("rsw", SW, raddr, rdata, 1'b0, 32'h0, 0);
      end
      foreach (model[a]) do_req("rlw", LW, 32'(a), 32'h0, 1'b0, model[a], 0);

      // zero-wait instance: stream with req_valid held high
      s_op[0] = SW; s_addr[0] = 32'h10; s_data[0] = 32'hA5A50010; s_exp[0] = 32'h0;
      s_op[1] = SW; s_addr[1] = 32'h14; s_data[1] = 32'h5A5A0014; s_exp[1] = 32'h0;
      s_op[2] = LW; s_addr[2] = 32'h10; s_data[2] = 32'h0;        s_exp[2] = 32'hA5A50010;
      s_op[3] = LW; s_addr[3] = 32'h14; s_data[3] = 32'h0;        s_exp[3] = 32'h5A5A0014;
      k = 0; n_rsp = 0; last_acc = 0;
      req0_op = s_op[0]; req0_addr = s_addr[0]; req0_wdata = s_data[0]; req0_valid = 1'b1;
      for (int c = 0; c < 40 && n_rsp < 4; c++) begin
         @(negedge clock);
         acc_now = (req0_ready === 1'b1) && (k < 4);
         if (rsp0_valid === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
            chk("z_rsp", 64'({rsp0_err, rsp0_rdata}), 64'(e));
            chk("z_lat", 64'(cyc - last_acc), 64'(1));
            n_rsp++;
         end
         if (acc_now) begin
            if (k > 0) chk("z_gap", 64'(cyc + 1 - last_acc), 64'(3));
            last_acc = cyc + 1;
            exp_q.push_back({1'b0, s_exp[k]});
            k++;
         end
         @(posedge clock); #1;
         if (acc_now) begin
            if (k < 4) begin
               req0_op = s_op[k]; req0_addr = s_addr[k]; req0_wdata = s_data[k];
            end else begin
               req0_valid = 1'b0;
            end
         end
      end
      req0_valid = 1'b0;
      chk("z_count", 64'(n_rsp), 64'(4));

      // reset during WAIT of a store
      do_req("sw20z", SW, 32'h20, 32'h0, 1'b0, 32'h0, 0);
      @(negedge clock);
      req_valid = 1'b1; req_op = SW; req_addr = 32'h20; req_wdata = 32'h12345678;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clock); n++; end
      @(posedge clock); #1;
      req_valid = 1'b0;
      chk("mid_busy", 64'({busy, state_dbg}), 64'({1'b1, 2'd1}));
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      chk("mid_rst", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, busy, state_dbg}), 64'(0));
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      chk("mid_ready", 64'(req_ready), 64'(1));
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         if (rsp_valid !== 1'b0) n++;
      end
      chk("mid_norsp", 64'(n), 64'(0));
      do_req("lw20", LW, 32'h20, 32'h0, 1'b0, 32'h0, 0);

      chk("q_empty", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
